// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one combinational instruction-memory port between fetch (priority) and loader (starvation-guarded, lockable bursts); IMEM_ARB_PERF_EN adds perf_if_gnt/perf_ld_gnt/perf_if_stall counters
module imem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic              ld_lock,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_gnt,
  output logic [31:0]       perf_ld_gnt,
  output logic [31:0]       perf_if_stall
`endif
);
  typedef enum logic [1:0] {ARB_IDLE, ARB_FETCH, ARB_LOAD, ARB_LOCK} state_t;
  state_t state, state_nx;
  logic [3:0] starve_cnt, starve_nx;
  logic locked, ld_wins, if_mis;
  always_comb begin
    locked = state == ARB_LOCK && ld_lock;
    ld_wins = ld_req && (locked || !if_req || starve_cnt == 4'(STARVE_MAX));
    ld_gnt = !rst && ld_wins;
    if_gnt = !rst && if_req && !ld_wins && !locked;
    if_mis = if_addr[1:0] != 2'b00;
    mem_ce = ld_gnt || (if_gnt && !if_mis);
    mem_we = ld_gnt && ld_we;
    mem_addr = ld_gnt ? ld_addr : if_gnt ? if_addr : '0;
    mem_wdata = ld_gnt ? ld_wdata : '0;
    state_nx = (locked || (ld_gnt && ld_lock)) ? ARB_LOCK : ld_gnt ? ARB_LOAD : if_gnt ? ARB_FETCH : ARB_IDLE;
    starve_nx = (ld_gnt || !ld_req) ? 4'd0 : (if_gnt && starve_cnt != 4'(STARVE_MAX)) ? starve_cnt + 4'd1 : starve_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      starve_cnt <= '0;
      if_rvalid <= 1'b0;
      if_err <= 1'b0;
      if_rdata <= '0;
      ld_rvalid <= 1'b0;
      ld_rdata <= '0;
    end else begin
      state <= state_nx;
      starve_cnt <= starve_nx;
      if_rvalid <= if_gnt;
      if_err <= if_gnt && if_mis;
      ld_rvalid <= ld_gnt;
      if (if_gnt) if_rdata <= if_mis ? '0 : mem_rdata;
      if (ld_gnt) ld_rdata <= ld_we ? '0 : mem_rdata;
    end
  end
`ifdef IMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_gnt <= '0;
      perf_ld_gnt <= '0;
      perf_if_stall <= '0;
    end else begin
      perf_if_gnt <= perf_if_gnt + 32'(if_gnt);
      perf_ld_gnt <= perf_ld_gnt + 32'(ld_gnt);
      perf_if_stall <= perf_if_stall + 32'(if_req && !if_gnt);
    end
  end
`endif
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scoreboard bench for imem_arbiter
module tb_imem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 0, ld_req = 0, ld_we = 0, ld_lock = 0;
  logic [31:0] if_addr = 0, ld_addr = 0, ld_wdata = 0, mem_rdata = 0;
  logic if_gnt, if_rvalid, if_err, ld_gnt, ld_rvalid, mem_ce, mem_we;
  logic [31:0] if_rdata, ld_rdata, mem_addr, mem_wdata;
`ifdef IMEM_ARB_PERF_EN
  logic [31:0] perf_if_gnt, perf_ld_gnt, perf_if_stall;
`endif
  int total = 0, bad = 0;
  int exp_pif = 0, exp_pld = 0, exp_pst = 0;
  typedef struct {logic is_if; logic [31:0] data; logic err;} rsp_t;
  rsp_t q[$];
  always #5 clk = ~clk;
  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_PERF_EN
    , .perf_if_gnt(perf_if_gnt), .perf_ld_gnt(perf_ld_gnt), .perf_if_stall(perf_if_stall)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic e_if, input logic e_ld, input logic e_ce, input logic e_we, input logic [31:0] rd);
    rsp_t e;
    mem_rdata = rd;
    #1;
    chk("if_gnt", 32'(if_gnt), 32'(e_if));
    chk("ld_gnt", 32'(ld_gnt), 32'(e_ld));
    chk("mem_ce", 32'(mem_ce), 32'(e_ce));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_if) chk("mem_addr_if", mem_addr, if_addr);
    if (e_ld) begin
      chk("mem_addr_ld", mem_addr, ld_addr);
      chk("mem_wdata_ld", mem_wdata, ld_wdata);
    end
    if (e_if) q.push_back('{1'b1, (if_addr[1:0] != 2'b00) ? 32'h0 : rd, if_addr[1:0] != 2'b00});
    if (e_ld) q.push_back('{1'b0, ld_we ? 32'h0 : rd, 1'b0});
    if (rst) begin
      exp_pif = 0;
      exp_pld = 0;
      exp_pst = 0;
    end else begin
      exp_pif += int'(e_if);
      exp_pld += int'(e_ld);
      exp_pst += int'(if_req && !e_if);
    end
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("if_rvalid", 32'(if_rvalid), 32'(e.is_if));
      chk("ld_rvalid", 32'(ld_rvalid), 32'(!e.is_if));
      if (e.is_if) begin
        chk("if_rdata", if_rdata, e.data);
        chk("if_err", 32'(if_err), 32'(e.err));
      end else chk("ld_rdata", ld_rdata, e.data);
    end else begin
      chk("if_rvalid_idle", 32'(if_rvalid), 32'd0);
      chk("ld_rvalid_idle", 32'(ld_rvalid), 32'd0);
    end
  endtask
  initial begin
    if_req = 1; ld_req = 1;
    step(0, 0, 0, 0, $urandom());
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_ld_rdata", ld_rdata, 32'h0);
    chk("rst_if_err", 32'(if_err), 32'd0);
    rst = 0; ld_req = 0; if_addr = 32'h0;
    step(1, 0, 1, 0, 32'h02000193);
    if_req = 0;
    step(0, 0, 0, 0, $urandom());
    if_req = 1; if_addr = 32'h4; ld_req = 1; ld_addr = 32'h10;
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, $urandom());
    step(0, 1, 1, 0, $urandom());
    step(1, 0, 1, 0, $urandom());
    ld_lock = 1; ld_we = 1; ld_addr = 32'h8; ld_wdata = 32'h04018213; if_addr = 32'h8;
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, $urandom());
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, $urandom());
    ld_req = 0;
    step(0, 0, 0, 0, $urandom());
    ld_req = 1;
    step(0, 1, 1, 1, $urandom());
    ld_lock = 0;
    step(1, 0, 1, 0, $urandom());
    ld_req = 0; if_addr = 32'h6;
    step(1, 0, 0, 0, $urandom());
    if_req = 0; ld_req = 1; ld_we = 0; ld_addr = 32'h20;
    step(0, 1, 1, 0, $urandom());
    ld_lock = 1;
    step(0, 1, 1, 0, $urandom());
    if_req = 1; if_addr = 32'hC; rst = 1;
    step(0, 0, 0, 0, $urandom());
    rst = 0;
    step(1, 0, 1, 0, $urandom());
    step(1, 0, 1, 0, $urandom());
    ld_req = 0; ld_lock = 0;
    step(1, 0, 1, 0, $urandom());
    if_req = 0;
    step(0, 0, 0, 0, $urandom());
`ifdef IMEM_ARB_PERF_EN
    chk("perf_if_gnt", perf_if_gnt, 32'(exp_pif));
    chk("perf_ld_gnt", perf_ld_gnt, 32'(exp_pld));
    chk("perf_if_stall", perf_if_stall, 32'(exp_pst));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
